// File: rtl/lsu_sized_pkg.sv
// Shared types and constants for the sized load-store unit: warp phases,
// access sizes, LSU state encodings and the base byte-strobe patterns.
package lsu_sized_pkg;

   typedef enum logic [2:0] {
      WARP_IDLE    = 3'd0,
      WARP_FETCH   = 3'd1,
      WARP_DECODE  = 3'd2,
      WARP_REQUEST = 3'd3,
      WARP_WAIT    = 3'd4,
      WARP_EXECUTE = 3'd5,
      WARP_UPDATE  = 3'd6,
      WARP_DONE    = 3'd7
   } warp_state_t;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_size_t;

   // Plain vector with named constants so older code comparing raw values keeps working
   typedef logic [2:0] lsu_state_t;

   localparam lsu_state_t LSU_IDLE       = 3'd0;
   localparam lsu_state_t LSU_REQUESTING = 3'd1;
   localparam lsu_state_t LSU_WAITING    = 3'd2;
   localparam lsu_state_t LSU_DONE       = 3'd3;
   localparam lsu_state_t LSU_ERROR      = 3'd4;

   // Strobe patterns for lane 0; word strobes are all ones at any data width
   localparam logic [1:0] STRB_BYTE = 2'b01;
   localparam logic [1:0] STRB_HALF = 2'b11;

endpackage

// File: rtl/lsu_sized_if.sv
// Data-memory bus between one LSU lane and the memory arbiter.
// master = LSU side, slave = arbiter/memory side.
interface lsu_sized_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic                      mem_read_valid;
   logic [ADDR_WIDTH-1:0]     mem_read_address;
   logic                      mem_read_ready;
   logic [DATA_WIDTH-1:0]     mem_read_data;
   logic                      mem_write_valid;
   logic [ADDR_WIDTH-1:0]     mem_write_address;
   logic [DATA_WIDTH-1:0]     mem_write_data;
   logic [DATA_WIDTH/8-1:0]   mem_write_strobe;
   logic                      mem_write_ready;

   modport master (
      output mem_read_valid, mem_read_address,
      input  mem_read_ready, mem_read_data,
      output mem_write_valid, mem_write_address, mem_write_data, mem_write_strobe,
      input  mem_write_ready
   );

   modport slave (
      input  mem_read_valid, mem_read_address,
      output mem_read_ready, mem_read_data,
      input  mem_write_valid, mem_write_address, mem_write_data, mem_write_strobe,
      output mem_write_ready
   );
endinterface

// File: rtl/lsu_sized_lane_align.sv
// Combinational byte-lane steering: places store data and strobes into the
// addressed lane, and pulls load data out of a lane with sign/zero extension.
module lsu_sized_lane_align
   import lsu_sized_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  mem_size_t                        i_size,
   input  logic [$clog2(DATA_WIDTH/8)-1:0]  i_lo,
   input  logic                             i_unsigned,
   input  logic [DATA_WIDTH-1:0]            i_store_src,
   input  logic [DATA_WIDTH-1:0]            i_read_word,
   output logic [DATA_WIDTH-1:0]            o_store_data,
   output logic [DATA_WIDTH/8-1:0]          o_strobe,
   output logic [DATA_WIDTH-1:0]            o_load_data
);
   localparam int NB = DATA_WIDTH / 8;

   logic        [7:0]  w_byte;
   logic        [15:0] w_half;
   logic signed [7:0]  w_byte_s;
   logic signed [15:0] w_half_s;

   assign w_byte   = i_read_word[{i_lo, 3'b000} +: 8];
   assign w_half   = i_read_word[{i_lo, 3'b000} +: 16];
   assign w_byte_s = $signed(w_byte);
   assign w_half_s = $signed(w_half);

   // Store side: shift the low bytes of the source and the base strobe into lane lo
   always_comb begin
      o_store_data = i_store_src;
      o_strobe     = '1;
      case (i_size)
         MEM_BYTE: begin
            o_store_data = DATA_WIDTH'(i_store_src[7:0]) << {i_lo, 3'b000};
            o_strobe     = NB'(STRB_BYTE) << i_lo;
         end
         MEM_HALF: begin
            o_store_data = DATA_WIDTH'(i_store_src[15:0]) << {i_lo, 3'b000};
            o_strobe     = NB'(STRB_HALF) << i_lo;
         end
         default: begin
            o_store_data = i_store_src;
            o_strobe     = '1;
         end
      endcase
   end

   // Load side: select the lane and extend; full-width loads pass straight through
   always_comb begin
      o_load_data = i_read_word;
      case (i_size)
         MEM_BYTE: o_load_data = i_unsigned ? DATA_WIDTH'(w_byte) : DATA_WIDTH'(w_byte_s);
         MEM_HALF: o_load_data = i_unsigned ? DATA_WIDTH'(w_half) : DATA_WIDTH'(w_half_s);
         default:  o_load_data = i_read_word;
      endcase
   end

endmodule

// File: rtl/lsu_sized.sv
// Per-lane load-store unit with byte/half/word accesses, misalignment
// detection and a response watchdog so a stuck access ends in ERROR.
module lsu_sized
   import lsu_sized_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TIMER_WIDTH    = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  warp_state_t            warp_state,
   input  logic                   decoded_mem_read_enable,
   input  logic                   decoded_mem_write_enable,
   input  mem_size_t              decoded_mem_size,
   input  logic                   decoded_mem_unsigned,
   input  logic [DATA_WIDTH-1:0]  rs1,
   input  logic [DATA_WIDTH-1:0]  rs2,
   input  logic [DATA_WIDTH-1:0]  imm,
   lsu_sized_if.master            mem,
   output lsu_state_t             lsu_state,
   output logic [DATA_WIDTH-1:0]  lsu_out,
   output logic                   lsu_error
);
   localparam int NB      = DATA_WIDTH / 8;
   localparam int LO_W    = $clog2(NB);
   localparam int TW      = (TIMER_WIDTH > 0) ? TIMER_WIDTH : 1;
   localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

   lsu_state_t              r_state;
   logic                    r_is_store;
   mem_size_t               r_size;
   logic                    r_unsigned;
   logic [ADDR_WIDTH-1:0]   r_ea;
   logic [TW-1:0]           r_timer;
   logic                    r_rd_valid;
   logic [ADDR_WIDTH-1:0]   r_rd_addr;
   logic                    r_wr_valid;
   logic [ADDR_WIDTH-1:0]   r_wr_addr;
   logic [DATA_WIDTH-1:0]   r_wr_data;
   logic [NB-1:0]           r_wr_strobe;
   logic [DATA_WIDTH-1:0]   r_lsu_out;
   logic                    r_error;

   logic [ADDR_WIDTH-1:0]   w_ea;
   logic [ADDR_WIDTH-1:0]   w_bus_addr;
   logic                    w_misaligned;
   logic [TW-1:0]           w_timer_nxt;
   logic                    w_timeout;
   logic [DATA_WIDTH-1:0]   w_store_data;
   logic [NB-1:0]           w_strobe;
   logic [DATA_WIDTH-1:0]   w_load_data;

   // Effective address wraps at the register width, then keeps only the memory address bits
   assign w_ea        = ADDR_WIDTH'(rs1 + imm);
   assign w_bus_addr  = {r_ea[ADDR_WIDTH-1:LO_W], {LO_W{1'b0}}};
   assign w_timer_nxt = r_timer + TW'(1);
   assign w_timeout   = WDOG_EN && (w_timer_nxt == TW'(TIMEOUT_CYCLES));

   // Alignment of the incoming request; the unused size encoding is treated as illegal
   always_comb begin
      w_misaligned = 1'b0;
      case (decoded_mem_size)
         MEM_BYTE: w_misaligned = 1'b0;
         MEM_HALF: w_misaligned = w_ea[0];
         MEM_WORD: w_misaligned = (w_ea[LO_W-1:0] != '0);
         default:  w_misaligned = 1'b1;
      endcase
   end

   // Lane steering works from the size/offset captured when the request was accepted
   lsu_sized_lane_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_lane_align (
      .i_size       (r_size),
      .i_lo         (r_ea[LO_W-1:0]),
      .i_unsigned   (r_unsigned),
      .i_store_src  (rs2),
      .i_read_word  (mem.mem_read_data),
      .o_store_data (w_store_data),
      .o_strobe     (w_strobe),
      .o_load_data  (w_load_data)
   );

   // Access FSM with watchdog; everything freezes while the lane is disabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= LSU_IDLE;
         r_is_store  <= 1'b0;
         r_size      <= MEM_BYTE;
         r_unsigned  <= 1'b0;
         r_ea        <= '0;
         r_timer     <= '0;
         r_rd_valid  <= 1'b0;
         r_rd_addr   <= '0;
         r_wr_valid  <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_wr_strobe <= '0;
         r_lsu_out   <= '0;
         r_error     <= 1'b0;
      end else if (enable) begin
         case (r_state)
            LSU_IDLE: begin
               if (warp_state == WARP_REQUEST) begin
                  if (decoded_mem_read_enable && decoded_mem_write_enable) begin
                     r_state <= LSU_ERROR;
                     r_error <= 1'b1;
                  end else if (decoded_mem_read_enable || decoded_mem_write_enable) begin
                     r_is_store <= decoded_mem_write_enable;
                     r_size     <= decoded_mem_size;
                     r_unsigned <= decoded_mem_unsigned;
                     r_ea       <= w_ea;
                     if (w_misaligned) begin
                        r_state <= LSU_ERROR;
                        r_error <= 1'b1;
                     end else begin
                        r_state <= LSU_REQUESTING;
                     end
                  end
               end
            end
            LSU_REQUESTING: begin
               r_timer <= '0;
               if (r_is_store) begin
                  r_wr_valid  <= 1'b1;
                  r_wr_addr   <= w_bus_addr;
                  r_wr_data   <= w_store_data;
                  r_wr_strobe <= w_strobe;
               end else begin
                  r_rd_valid  <= 1'b1;
                  r_rd_addr   <= w_bus_addr;
               end
               r_state <= LSU_WAITING;
            end
            LSU_WAITING: begin
               // A ready arriving on the limit cycle still completes the access
               if (!r_is_store && mem.mem_read_ready) begin
                  r_rd_valid <= 1'b0;
                  r_lsu_out  <= w_load_data;
                  r_state    <= LSU_DONE;
               end else if (r_is_store && mem.mem_write_ready) begin
                  r_wr_valid <= 1'b0;
                  r_state    <= LSU_DONE;
               end else begin
                  r_timer <= w_timer_nxt;
                  if (w_timeout) begin
                     r_rd_valid <= 1'b0;
                     r_wr_valid <= 1'b0;
                     r_error    <= 1'b1;
                     r_state    <= LSU_ERROR;
                  end
               end
            end
            LSU_DONE, LSU_ERROR: begin
               if (warp_state == WARP_UPDATE) begin
                  r_state <= LSU_IDLE;
                  r_error <= 1'b0;
               end
            end
            default: begin
               r_state <= LSU_IDLE;
            end
         endcase
      end
   end

   assign mem.mem_read_valid    = r_rd_valid;
   assign mem.mem_read_address  = r_rd_addr;
   assign mem.mem_write_valid   = r_wr_valid;
   assign mem.mem_write_address = r_wr_addr;
   assign mem.mem_write_data    = r_wr_data;
   assign mem.mem_write_strobe  = r_wr_strobe;
   assign lsu_state             = r_state;
   assign lsu_out               = r_lsu_out;
   assign lsu_error             = r_error;

endmodule

// File: tb/tb_lsu_sized.sv
// Self-checking bench for lsu_sized: directed scenarios plus randomized
// transactions, compared against a byte-arithmetic model of each access.
module tb_lsu_sized;
   import lsu_sized_pkg::*;

   localparam int DW = 32;
   localparam int AW = 8;
   localparam int TO = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   warp_state_t  warp_state;
   logic         rd_en, wr_en;
   mem_size_t    msize;
   logic         uns;
   logic [DW-1:0] rs1, rs2, imm;
   lsu_state_t   lsu_state;
   logic [DW-1:0] lsu_out;
   logic         lsu_error;

   lsu_sized_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   lsu_sized #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .warp_state(warp_state),
      .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
      .decoded_mem_size(msize), .decoded_mem_unsigned(uns),
      .rs1(rs1), .rs2(rs2), .imm(imm), .mem(bus),
      .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_error(lsu_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_out = '0;
   logic [AW-1:0] seen_addr;
   logic [DW-1:0] seen_wdata;
   logic [3:0]    seen_strb;

   typedef struct packed {
      logic          err;
      logic [7:0]    addr;
      logic [31:0]   wdata;
      logic [3:0]    strb;
      logic [31:0]   ldval;
   } exp_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // Reference: plain byte arithmetic on the effective address
   function automatic exp_t model(input bit rd, input bit wr, input int size, input bit u,
                                  input bit [31:0] a, input bit [31:0] off,
                                  input bit [31:0] sdata, input bit [31:0] rdata);
      exp_t m;
      bit [31:0] sum;
      int ea, lo, nbytes;
      longint unsigned mask, lane;
      sum    = a + off;
      ea     = int'(sum[7:0]);
      lo     = ea % 4;
      nbytes = (size == 0) ? 1 : (size == 1) ? 2 : 4;
      mask   = (64'd1 << (8 * nbytes)) - 1;
      m.err  = (rd && wr) || ((ea % nbytes) != 0);
      m.addr = 8'(ea - lo);
      m.wdata = 32'((longint'(sdata) & mask) << (8 * lo));
      m.strb  = 4'(((1 << nbytes) - 1) << lo);
      lane = (longint'(rdata) >> (8 * lo)) & mask;
      if (!u && nbytes < 4 && lane[8 * nbytes - 1]) lane = lane | (~mask);
      m.ldval = 32'(lane);
      return m;
   endfunction

   // Invariants checked on every cycle out of reset
   always @(negedge clk) begin
      if (reset) begin
         chk("one_valid", {63'd0, bus.mem_read_valid & bus.mem_write_valid}, 64'd0);
         if (bus.mem_read_valid || bus.mem_write_valid)
            chk("valid_only_waiting", 64'(lsu_state), 64'(LSU_WAITING));
         chk("error_matches_state", {63'd0, lsu_error}, {63'd0, lsu_state == LSU_ERROR});
      end
   end

   task automatic set_req(input bit rd, input bit wr, input int size, input bit u,
                          input bit [31:0] a, input bit [31:0] off, input bit [31:0] sd);
      rd_en = rd; wr_en = wr; msize = mem_size_t'(size); uns = u;
      rs1 = a; imm = off; rs2 = sd;
   endtask

   task automatic update_to_idle(input string tag);
      warp_state = WARP_UPDATE;
      @(posedge clk); @(negedge clk);
      warp_state = WARP_WAIT;
      chk({tag, "_idle"}, 64'(lsu_state), 64'(LSU_IDLE));
      chk({tag, "_err_clr"}, {63'd0, lsu_error}, 64'd0);
      chk({tag, "_out_keep"}, 64'(lsu_out), 64'(exp_out));
   endtask

   // One full access; delay = WAITING cycle carrying ready (0 or >TO = never)
   task automatic run_txn(input string tag, input bit rd, input bit wr, input int size,
                          input bit u, input bit [31:0] a, input bit [31:0] off,
                          input bit [31:0] sd, input bit [31:0] rdata, input int delay);
      exp_t m;
      int vcount;
      bit fin;
      lsu_state_t end_state;
      m = model(rd, wr, size, u, a, off, sd, rdata);
      set_req(rd, wr, size, u, a, off, sd);
      bus.mem_read_data = rdata;
      warp_state = WARP_REQUEST;
      @(posedge clk); @(negedge clk);
      warp_state = WARP_WAIT;
      if (m.err) begin
         chk({tag, "_err_state"}, 64'(lsu_state), 64'(LSU_ERROR));
         chk({tag, "_err_flag"}, {63'd0, lsu_error}, 64'd1);
         chk({tag, "_no_valid"}, {62'd0, bus.mem_read_valid, bus.mem_write_valid}, 64'd0);
         end_state = LSU_ERROR;
      end else begin
         chk({tag, "_requesting"}, 64'(lsu_state), 64'(LSU_REQUESTING));
         @(posedge clk); @(negedge clk);
         vcount = 0;
         fin = 0;
         end_state = LSU_WAITING;
         for (int w = 1; w <= TO && !fin; w++) begin
            chk({tag, "_waiting"}, 64'(lsu_state), 64'(LSU_WAITING));
            chk({tag, "_rvalid"}, {63'd0, bus.mem_read_valid}, {63'd0, rd});
            chk({tag, "_wvalid"}, {63'd0, bus.mem_write_valid}, {63'd0, wr});
            if (rd) chk({tag, "_raddr"}, 64'(bus.mem_read_address), 64'(m.addr));
            if (wr) begin
               chk({tag, "_waddr"}, 64'(bus.mem_write_address), 64'(m.addr));
               chk({tag, "_wdata"}, 64'(bus.mem_write_data), 64'(m.wdata));
               chk({tag, "_wstrb"}, 64'(bus.mem_write_strobe), 64'(m.strb));
            end
            if (w == 1) begin
               seen_addr  = rd ? bus.mem_read_address : bus.mem_write_address;
               seen_wdata = bus.mem_write_data;
               seen_strb  = bus.mem_write_strobe;
            end
            if (bus.mem_read_valid || bus.mem_write_valid) vcount++;
            bus.mem_read_ready  = rd && (w == delay);
            bus.mem_write_ready = wr && (w == delay);
            @(posedge clk); @(negedge clk);
            bus.mem_read_ready  = 1'b0;
            bus.mem_write_ready = 1'b0;
            if (w == delay) begin
               if (rd) exp_out = m.ldval;
               end_state = LSU_DONE;
               fin = 1;
               chk({tag, "_done"}, 64'(lsu_state), 64'(LSU_DONE));
               chk({tag, "_done_noerr"}, {63'd0, lsu_error}, 64'd0);
            end else if (w == TO) begin
               end_state = LSU_ERROR;
               fin = 1;
               chk({tag, "_timeout_state"}, 64'(lsu_state), 64'(LSU_ERROR));
               chk({tag, "_timeout_err"}, {63'd0, lsu_error}, 64'd1);
            end
         end
         chk({tag, "_valid_off"}, {62'd0, bus.mem_read_valid, bus.mem_write_valid}, 64'd0);
         chk({tag, "_valid_cycles"}, 64'(vcount),
             64'((delay >= 1 && delay <= TO) ? delay : TO));
      end
      chk({tag, "_lsu_out"}, 64'(lsu_out), 64'(exp_out));
      @(posedge clk); @(negedge clk);
      chk({tag, "_hold"}, 64'(lsu_state), 64'(end_state));
      update_to_idle(tag);
   endtask

   // Drive a load up to its first WAITING cycle
   task automatic load_to_waiting(input bit [31:0] a, input bit [31:0] rdata);
      set_req(1'b1, 1'b0, 2, 1'b0, a, 32'd0, 32'd0);
      bus.mem_read_data = rdata;
      warp_state = WARP_REQUEST;
      @(posedge clk); @(negedge clk);
      warp_state = WARP_WAIT;
      @(posedge clk); @(negedge clk);
      chk("pre_waiting", 64'(lsu_state), 64'(LSU_WAITING));
      chk("pre_rvalid", {63'd0, bus.mem_read_valid}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; enable = 1'b1; warp_state = WARP_IDLE;
      set_req(1'b0, 1'b0, 0, 1'b0, 32'd0, 32'd0, 32'd0);
      bus.mem_read_ready = 1'b0; bus.mem_write_ready = 1'b0; bus.mem_read_data = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_state", 64'(lsu_state), 64'(LSU_IDLE));
      chk("rst_valids", {62'd0, bus.mem_read_valid, bus.mem_write_valid}, 64'd0);
      chk("rst_addrs", {48'd0, bus.mem_read_address, bus.mem_write_address}, 64'd0);
      chk("rst_wdata", 64'(bus.mem_write_data), 64'd0);
      chk("rst_strobe", 64'(bus.mem_write_strobe), 64'd0);
      chk("rst_out", 64'(lsu_out), 64'd0);
      chk("rst_err", {63'd0, lsu_error}, 64'd0);

      // No enable at REQUEST: stays idle
      warp_state = WARP_REQUEST;
      @(posedge clk); @(negedge clk);
      warp_state = WARP_WAIT;
      chk("noop_idle", 64'(lsu_state), 64'(LSU_IDLE));

      // Signed then unsigned byte load from 0x13
      run_txn("ldb_s", 1, 0, 0, 0, 32'h10, 32'd3, 32'd0, 32'h80AABBCC, 2);
      chk("ldb_s_addr_lit", 64'(seen_addr), 64'h10);
      chk("ldb_s_out_lit", 64'(lsu_out), 64'hFFFFFF80);
      run_txn("ldb_u", 1, 0, 0, 1, 32'h10, 32'd3, 32'd0, 32'h80AABBCC, 1);
      chk("ldb_u_out_lit", 64'(lsu_out), 64'h00000080);

      // Half store to 0x22
      run_txn("sth", 0, 1, 1, 0, 32'h20, 32'd2, 32'h1234ABCD, 32'd0, 3);
      chk("sth_addr_lit", 64'(seen_addr), 64'h20);
      chk("sth_data_lit", 64'(seen_wdata), 64'hABCD0000);
      chk("sth_strb_lit", 64'(seen_strb), 64'hC);

      // Misaligned half load, both enables, misaligned word store
      run_txn("mis_h", 1, 0, 1, 0, 32'h20, 32'd1, 32'd0, 32'd0, 1);
      run_txn("both", 1, 1, 2, 0, 32'h40, 32'd0, 32'd0, 32'd0, 1);
      run_txn("mis_w", 0, 1, 2, 0, 32'h42, 32'd0, 32'h55, 32'd0, 1);

      // Watchdog: never ready, then ready on the limit cycle
      run_txn("wdog", 1, 0, 2, 0, 32'h44, 32'd0, 32'd0, 32'h11223344, 0);
      run_txn("wdog_edge", 1, 0, 2, 0, 32'h44, 32'd0, 32'd0, 32'h11223344, 4);
      chk("wdog_edge_lit", 64'(lsu_out), 64'h11223344);

      // Asynchronous reset in the middle of WAITING
      load_to_waiting(32'h48, 32'hDEADBEEF);
      #2 reset = 1'b0;
      #1;
      exp_out = '0;
      chk("arst_rvalid", {63'd0, bus.mem_read_valid}, 64'd0);
      chk("arst_state", 64'(lsu_state), 64'(LSU_IDLE));
      chk("arst_err", {63'd0, lsu_error}, 64'd0);
      chk("arst_out", 64'(lsu_out), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Disabled lane holds through ready, resumes on re-enable
      load_to_waiting(32'h4C, 32'hCAFEF00D);
      enable = 1'b0;
      bus.mem_read_ready = 1'b1;
      for (int i = 0; i < TO + 2; i++) begin
         @(posedge clk); @(negedge clk);
         chk("dis_state", 64'(lsu_state), 64'(LSU_WAITING));
         chk("dis_rvalid", {63'd0, bus.mem_read_valid}, 64'd1);
         chk("dis_out", 64'(lsu_out), 64'(exp_out));
      end
      enable = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.mem_read_ready = 1'b0;
      exp_out = 32'hCAFEF00D;
      chk("reen_done", 64'(lsu_state), 64'(LSU_DONE));
      chk("reen_out", 64'(lsu_out), 64'(exp_out));
      update_to_idle("reen");

      // Randomized accesses
      for (int t = 0; t < 60; t++) begin
         int r;
         bit rd, wr;
         r  = int'($urandom_range(0, 9));
         rd = (r == 0) || (r[0] == 1'b1);
         wr = (r == 0) || (r[0] == 1'b0);
         run_txn("rnd", rd, wr, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)),
                 $urandom, 32'($urandom_range(0, 7)), $urandom, $urandom,
                 int'($urandom_range(1, TO + 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_sized.md
Name: lsu_sized

Overview:
- Parametrised successor to the per-thread load-store unit; one instance per thread lane in each core.
- Executes LDR/STR-class instructions with byte, half and word access sizes, with sign or zero extension on loads.
- Adds byte-enable writes, misalignment detection and a response watchdog. An access that cannot complete ends in an error state instead of hanging the warp.
- Sits between the warp scheduler/register file and the data-memory arbiter. It uses the same warp_state REQUEST/UPDATE handshake as the existing LSU.

Parameters:
- DATA_WIDTH, 32, register/memory word width; must be 16, 32 or 64 (a power of two, at least 16).
- ADDR_WIDTH, 8, data-memory byte-address width.
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAITING before error; 0 disables the watchdog.
- TIMER_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of the watchdog counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  lane active; when low all state and outputs hold
- warp_state  in  warp_state_t  warp phase
- decoded_mem_read_enable  in  1  load instruction
- decoded_mem_write_enable  in  1  store instruction
- decoded_mem_size  in  mem_size_t  MEM_BYTE / MEM_HALF / MEM_WORD
- decoded_mem_unsigned  in  1  zero-extend loads when set
- rs1, rs2, imm  in  DATA_WIDTH  base, store data, offset
- mem_read_valid  out  1  read request
- mem_read_address  out  ADDR_WIDTH  word-aligned byte address
- mem_read_ready  in  1  read response valid
- mem_read_data  in  DATA_WIDTH  full word read
- mem_write_valid  out  1  write request
- mem_write_address  out  ADDR_WIDTH  word-aligned byte address
- mem_write_data  out  DATA_WIDTH  lane-steered store data
- mem_write_strobe  out  DATA_WIDTH/8  byte enables
- mem_write_ready  in  1  write accepted
- lsu_state  out  lsu_state_t  IDLE/REQUESTING/WAITING/DONE/ERROR
- lsu_out  out  DATA_WIDTH  extended load result
- lsu_error  out  1  misaligned, illegal or timed-out access

Behaviour:
- Reset (reset low, asynchronous):
  - lsu_state=LSU_IDLE.
  - All valids, addresses, write data, strobe, lsu_out, lsu_error and the watchdog timer are 0.
  - Outputs clear immediately, including in the middle of a transaction.
- Address arithmetic:
  - ea = rs1 + imm, modulo 2^DATA_WIDTH, then truncated to ADDR_WIDTH.
  - The lane offset lo is ea[log2(DATA_WIDTH/8)-1:0].
  - The bus address is ea with the lo bits cleared.
- Alignment:
  - Byte access: always aligned.
  - Half access: requires ea[0]=0.
  - Word access: requires lo=0.
- IDLE: acts only when warp_state==WARP_REQUEST.
  - Both read and write enables high: ERROR with lsu_error=1; no memory request is issued.
  - Exactly one enable high and the access is misaligned: ERROR with lsu_error=1; no request.
  - Exactly one enable high and the access is aligned: REQUESTING.
  - Neither enable high: stay IDLE.
- REQUESTING (one cycle):
  - Assert the read or write valid with the bus address. The timer is cleared.
  - Stores: rs2's low bytes are shifted into lane lo, all other bits are 0.
  - Store strobe is 1, 3 or 0xF (width-appropriate) shifted left by lo.
  - Next state: WAITING.
- WAITING:
  - Ready is sampled every cycle, including the first.
  - Load with mem_read_ready=1: deassert valid; lsu_out = selected lane, sign- or zero-extended per decoded_mem_unsigned (word loads pass through unchanged); go to DONE.
  - Store with mem_write_ready=1: deassert valid, go to DONE; lsu_out is unchanged.
  - Watchdog: the timer increments on each WAITING cycle without ready. When TIMEOUT_CYCLES!=0 and the timer reaches TIMEOUT_CYCLES, deassert valid, set lsu_error=1, go to ERROR.
  - If ready arrives in the same cycle the limit is hit, ready wins.
- DONE / ERROR:
  - Hold all outputs.
  - On WARP_UPDATE: go to IDLE and clear lsu_error. lsu_out persists until the next completed load.
- Exactly one valid is high at a time. A valid never drops before its ready, except on timeout or reset.

Decomposition:
- Additions to common.svh:
  - mem_size_t (2-bit).
  - LSU_ERROR appended to lsu_state_t.
  - Shared strobe-pattern constants.
- Sub-module lsu_lane_align: combinational; steers store data and generates strobes, and extracts/extends load data given size, lo and unsigned flag.
- The FSM and watchdog stay in lsu_sized.

Test Plan:
- Signed byte load: DATA_WIDTH=32, rs1=0x10, imm=3, MEM_BYTE, signed, read data 0x80AABBCC, ready on the 2nd WAITING cycle. Required: read address 0x10; lsu_out=0xFFFFFF80; DONE; IDLE after WARP_UPDATE. Repeated unsigned: lsu_out=0x00000080.
- Half store: ea=0x22, rs2=0x1234ABCD. Required: write address 0x20, data 0xABCD0000, strobe 0b1100; DONE on ready.
- Misaligned half load: ea=0x21. Required: ERROR the cycle after REQUEST, lsu_error=1, mem_read_valid never asserted; IDLE with error cleared on UPDATE.
- Watchdog: TIMEOUT_CYCLES=4, ready held 0. Required: valid high exactly 4 WAITING cycles, then 0, lsu_error=1, ERROR. Separate case: ready on the 4th cycle gives DONE, no error.
- Both enables high at REQUEST. Required: ERROR, no valid asserted.
- Reset low mid-WAITING with valid=1. Required: valid, state and error all 0/IDLE asynchronously, before the next clk edge. enable=0 mid-WAITING: all outputs held; resumes on re-enable.
